fifo_deq_serializer: RTL and testbench



---
 rtl/fifo_deq_serializer_if.sv | 36 +++
 rtl/fifo_deq_serializer.sv | 80 ++++++++
 tb/tb_fifo_deq_serializer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_deq_serializer_if.sv
// Handshake bundle between an upstream FIFO (first/deq) and a downstream
// enq method, as seen by the wide-to-narrow serializer.
interface fifo_deq_serializer_if #(
  parameter int DATA_WIDTH = 384,
  parameter int BEAT_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_first;
  logic                  in_first__RDY;
  logic                  in_deq__RDY;
  logic                  in_deq__ENA;
  logic                  out_enq__RDY;
  logic                  out_enq__ENA;
  logic [BEAT_WIDTH-1:0] out_enq_v;

  // Serializer side: consumes the FIFO head and produces beats
  modport master (
    input  in_first,
    input  in_first__RDY,
    input  in_deq__RDY,
    input  out_enq__RDY,
    output in_deq__ENA,
    output out_enq__ENA,
    output out_enq_v
  );

  // Environment side: the upstream FIFO plus the downstream sink
  modport slave (
    output in_first,
    output in_first__RDY,
    output in_deq__RDY,
    output out_enq__RDY,
    input  in_deq__ENA,
    input  out_enq__ENA,
    input  out_enq_v
  );
endinterface

// File: rtl/fifo_deq_serializer.sv
// Pulls one wide entry from an upstream FIFO and emits it as a stream of
// narrow beats, lowest beat first. A new entry can be captured in the same
// cycle the previous entry's last beat goes out, so entries stream without
// idle cycles in between.
module fifo_deq_serializer #(
  parameter int DATA_WIDTH = 384,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  fifo_deq_serializer_if.master  bus,
  output logic                   busy,
  output logic [3:0]             beat_idx
);

  localparam int         NBEATS    = DATA_WIDTH / BEAT_WIDTH;
  localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            beat_q, beat_d;

  logic                  sending;
  logic                  lastXfer;
  logic                  take;
  logic [BEAT_WIDTH-1:0] curBeat;

  assign sending  = (state_q == SEND);
  assign lastXfer = sending && (beat_q == LAST_BEAT) && bus.out_enq__RDY;
  assign take     = bus.in_first__RDY && bus.in_deq__RDY &&
                    ((state_q == IDLE) || lastXfer);
  assign curBeat  = data_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH];

  // Outputs are forced quiet while RST is high so nothing is enqueued or
  // dequeued in a reset cycle, even when the registers still hold old state.
  assign bus.in_deq__ENA  = take && !RST;
  assign bus.out_enq__ENA = sending && bus.out_enq__RDY && !RST;
  assign bus.out_enq_v    = (sending && !RST) ? curBeat : '0;
  assign busy             = sending && !RST;
  assign beat_idx         = RST ? 4'd0 : beat_q;

  // Next-state: capture wins over the final beat so back-to-back entries
  // overlap; otherwise advance on each accepted beat and stop at the last.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    beat_d  = beat_q;
    if (take) begin
      data_d  = bus.in_first;
      beat_d  = '0;
      state_d = SEND;
    end else if (sending && bus.out_enq__RDY) begin
      if (beat_q == LAST_BEAT) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 4'd1;
      end
    end
  end

  // State registers with synchronous reset; a reset mid-entry drops it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Self-checking bench for fifo_deq_serializer. Expected beats are queued
// when an entry is offered upstream and popped as the DUT emits beats.
module tb_fifo_deq_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        busy;
  logic [3:0]  beatIdx;

  fifo_deq_serializer_if #(.DATA_WIDTH(384), .BEAT_WIDTH(32)) bus ();

  fifo_deq_serializer #(.DATA_WIDTH(384), .BEAT_WIDTH(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .busy     (busy),
    .beat_idx (beatIdx)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] sbQ[$];
  logic [31:0] expV;

  logic        obsDeq, obsEna, obsBusy;
  logic [31:0] obsV;
  logic [3:0]  obsIdx;

  function automatic logic [383:0] makeEntry(input logic [31:0] base);
    logic [383:0] e;
    for (int k = 0; k < 12; k++) e[k*32 +: 32] = base + 32'(k);
    return e;
  endfunction

  task automatic pushEntry(input logic [31:0] base);
    for (int k = 0; k < 12; k++) sbQ.push_back(base + 32'(k));
  endtask

  // Samples outputs mid-cycle with the current inputs, then advances one clock
  task automatic sampleCycle();
    #1;
    obsDeq  = bus.in_deq__ENA;
    obsEna  = bus.out_enq__ENA;
    obsV    = bus.out_enq_v;
    obsBusy = busy;
    obsIdx  = beatIdx;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.in_first = makeEntry(32'hDEAD_0000);
    bus.in_first__RDY = 1'b1;
    bus.in_deq__RDY = 1'b1;
    bus.out_enq__RDY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sampleCycle();
      checks++; if (obsDeq !== 1'b0) $display("[TB] FAIL reset_deq: got %b expected 0", obsDeq); else passes++;
      checks++; if (obsEna !== 1'b0) $display("[TB] FAIL reset_ena: got %b expected 0", obsEna); else passes++;
      checks++; if (obsV !== 32'h0) $display("[TB] FAIL reset_v: got %h expected 0", obsV); else passes++;
      checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", obsBusy); else passes++;
      checks++; if (obsIdx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", obsIdx); else passes++;
    end
    RST = 1'b0;
    bus.in_first__RDY = 1'b0;
    sampleCycle();
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL post_reset_busy: got %b expected 0", obsBusy); else passes++;
    checks++; if (obsIdx !== 4'd0) $display("[TB] FAIL post_reset_idx: got %0d expected 0", obsIdx); else passes++;
    checks++; if (obsEna !== 1'b0) $display("[TB] FAIL post_reset_ena: got %b expected 0", obsEna); else passes++;
  endtask

  task automatic test_single_entry();
    int deqSeen;
    bus.in_first = makeEntry(32'h1000_0000);
    bus.in_first__RDY = 1'b1;
    bus.in_deq__RDY = 1'b1;
    bus.out_enq__RDY = 1'b1;
    pushEntry(32'h1000_0000);
    sampleCycle();
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL single_capture_deq: got %b expected 1", obsDeq); else passes++;
    checks++; if (obsEna !== 1'b0) $display("[TB] FAIL single_capture_ena: got %b expected 0", obsEna); else passes++;
    bus.in_first__RDY = 1'b0;
    deqSeen = 0;
    for (int i = 0; i < 12; i++) begin
      sampleCycle();
      deqSeen += int'(obsDeq);
      checks++; if (obsEna !== 1'b1) $display("[TB] FAIL single_ena: got %b expected 1 at beat %0d", obsEna, i); else passes++;
      checks++; if (obsIdx !== 4'(i)) $display("[TB] FAIL single_idx: got %0d expected %0d", obsIdx, i); else passes++;
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL single_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL single_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    checks++; if (deqSeen !== 0) $display("[TB] FAIL single_extra_deq: got %0d expected 0", deqSeen); else passes++;
    sampleCycle();
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL single_done_busy: got %b expected 0", obsBusy); else passes++;
    checks++; if (obsEna !== 1'b0) $display("[TB] FAIL single_done_ena: got %b expected 0", obsEna); else passes++;
  endtask

  task automatic test_back_to_back();
    bus.in_first = makeEntry(32'h2000_0000);
    bus.in_first__RDY = 1'b1;
    bus.in_deq__RDY = 1'b1;
    bus.out_enq__RDY = 1'b1;
    pushEntry(32'h2000_0000);
    sampleCycle();
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL b2b_first_deq: got %b expected 1", obsDeq); else passes++;
    bus.in_first = makeEntry(32'h2100_0000);
    pushEntry(32'h2100_0000);
    for (int i = 0; i < 24; i++) begin
      bus.in_first__RDY = (i <= 11);
      sampleCycle();
      checks++; if (obsEna !== 1'b1) $display("[TB] FAIL b2b_ena: got %b expected 1 at cycle %0d", obsEna, i); else passes++;
      checks++; if (obsIdx !== 4'(i % 12)) $display("[TB] FAIL b2b_idx: got %0d expected %0d", obsIdx, i % 12); else passes++;
      checks++; if (obsDeq !== (i == 11)) $display("[TB] FAIL b2b_deq: got %b expected %b at cycle %0d", obsDeq, (i == 11), i); else passes++;
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL b2b_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL b2b_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    sampleCycle();
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL b2b_done_busy: got %b expected 0", obsBusy); else passes++;
  endtask

  task automatic test_stall();
    bus.in_first = makeEntry(32'h3000_0000);
    bus.in_first__RDY = 1'b1;
    bus.in_deq__RDY = 1'b1;
    bus.out_enq__RDY = 1'b1;
    pushEntry(32'h3000_0000);
    sampleCycle();
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL stall_capture_deq: got %b expected 1", obsDeq); else passes++;
    bus.in_first__RDY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        bus.out_enq__RDY = 1'b0;
        for (int s = 0; s < 3; s++) begin
          sampleCycle();
          checks++; if (obsEna !== 1'b0) $display("[TB] FAIL stall_ena: got %b expected 0", obsEna); else passes++;
          checks++; if (obsIdx !== 4'd5) $display("[TB] FAIL stall_idx: got %0d expected 5", obsIdx); else passes++;
          checks++; if (obsV !== 32'h3000_0005) $display("[TB] FAIL stall_hold_v: got %h expected 30000005", obsV); else passes++;
          checks++; if (obsDeq !== 1'b0) $display("[TB] FAIL stall_deq: got %b expected 0", obsDeq); else passes++;
        end
        bus.out_enq__RDY = 1'b1;
      end
      sampleCycle();
      checks++; if (obsIdx !== 4'(i)) $display("[TB] FAIL stall_resume_idx: got %0d expected %0d", obsIdx, i); else passes++;
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL stall_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL stall_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    sampleCycle();
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL stall_done_busy: got %b expected 0", obsBusy); else passes++;
    checks++; if (sbQ.size() !== 0) $display("[TB] FAIL stall_leftover: got %0d expected 0", sbQ.size()); else passes++;
  endtask

  task automatic test_upstream_empty();
    bus.in_first__RDY = 1'b0;
    bus.in_deq__RDY = 1'b1;
    bus.out_enq__RDY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sampleCycle();
      checks++; if (obsDeq !== 1'b0) $display("[TB] FAIL empty_deq: got %b expected 0", obsDeq); else passes++;
      checks++; if (obsEna !== 1'b0) $display("[TB] FAIL empty_ena: got %b expected 0", obsEna); else passes++;
      checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL empty_busy: got %b expected 0", obsBusy); else passes++;
    end
    bus.in_first = makeEntry(32'h4000_0000);
    bus.in_first__RDY = 1'b1;
    pushEntry(32'h4000_0000);
    sampleCycle();
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL empty_rise_deq: got %b expected 1", obsDeq); else passes++;
    bus.in_first__RDY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sampleCycle();
      checks++; if (obsEna !== 1'b1) $display("[TB] FAIL empty_ena_after: got %b expected 1 at beat %0d", obsEna, i); else passes++;
      checks++; if (obsIdx !== 4'(i)) $display("[TB] FAIL empty_idx: got %0d expected %0d", obsIdx, i); else passes++;
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL empty_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL empty_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    sampleCycle();
  endtask

  task automatic test_reset_mid();
    bus.in_first = makeEntry(32'h5000_0000);
    bus.in_first__RDY = 1'b1;
    bus.in_deq__RDY = 1'b1;
    bus.out_enq__RDY = 1'b1;
    pushEntry(32'h5000_0000);
    sampleCycle();
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL rstmid_capture_deq: got %b expected 1", obsDeq); else passes++;
    bus.in_first__RDY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sampleCycle();
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL rstmid_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL rstmid_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    RST = 1'b1;
    bus.in_first = makeEntry(32'h5100_0000);
    bus.in_first__RDY = 1'b1;
    sampleCycle();
    checks++; if (obsEna !== 1'b0) $display("[TB] FAIL rstmid_ena: got %b expected 0", obsEna); else passes++;
    checks++; if (obsDeq !== 1'b0) $display("[TB] FAIL rstmid_deq: got %b expected 0", obsDeq); else passes++;
    repeat (5) if (sbQ.size() != 0) void'(sbQ.pop_front());
    RST = 1'b0;
    pushEntry(32'h5100_0000);
    sampleCycle();
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL rstmid_after_busy: got %b expected 0", obsBusy); else passes++;
    checks++; if (obsIdx !== 4'd0) $display("[TB] FAIL rstmid_after_idx: got %0d expected 0", obsIdx); else passes++;
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL rstmid_next_deq: got %b expected 1", obsDeq); else passes++;
    bus.in_first__RDY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sampleCycle();
      checks++; if (obsEna !== 1'b1) $display("[TB] FAIL rstmid_next_ena: got %b expected 1 at beat %0d", obsEna, i); else passes++;
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL rstmid_next_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL rstmid_next_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    sampleCycle();
    checks++; if (obsEna !== 1'b0) $display("[TB] FAIL rstmid_no_leftover: got %b expected 0", obsEna); else passes++;
  endtask

  task automatic test_deq_not_ready();
    bus.in_first = makeEntry(32'h6000_0000);
    bus.in_first__RDY = 1'b1;
    bus.in_deq__RDY = 1'b0;
    bus.out_enq__RDY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sampleCycle();
      checks++; if (obsDeq !== 1'b0) $display("[TB] FAIL nodeq_deq: got %b expected 0", obsDeq); else passes++;
      checks++; if (obsEna !== 1'b0) $display("[TB] FAIL nodeq_ena: got %b expected 0", obsEna); else passes++;
      checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL nodeq_busy: got %b expected 0", obsBusy); else passes++;
    end
    bus.in_deq__RDY = 1'b1;
    pushEntry(32'h6000_0000);
    sampleCycle();
    checks++; if (obsDeq !== 1'b1) $display("[TB] FAIL nodeq_rise_deq: got %b expected 1", obsDeq); else passes++;
    bus.in_first__RDY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sampleCycle();
      checks++; if (obsEna !== 1'b1) $display("[TB] FAIL nodeq_send_ena: got %b expected 1 at beat %0d", obsEna, i); else passes++;
      if (obsEna === 1'b1) begin
        checks++;
        if (sbQ.size() == 0) $display("[TB] FAIL nodeq_beat: got %h expected none (queue empty)", obsV);
        else begin
          expV = sbQ.pop_front();
          if (obsV !== expV) $display("[TB] FAIL nodeq_beat: got %h expected %h", obsV, expV); else passes++;
        end
      end
    end
    sampleCycle();
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL nodeq_done_busy: got %b expected 0", obsBusy); else passes++;
    checks++; if (sbQ.size() !== 0) $display("[TB] FAIL final_queue: got %0d expected 0", sbQ.size()); else passes++;
  endtask

  initial begin
    RST = 1'b1;
    bus.in_first = '0;
    bus.in_first__RDY = 1'b0;
    bus.in_deq__RDY = 1'b0;
    bus.out_enq__RDY = 1'b0;
    $display("[TB] starting fifo_deq_serializer bench");
    test_reset();
    test_single_entry();
    test_back_to_back();
    test_stall();
    test_upstream_empty();
    test_reset_mid();
    test_deq_not_ready();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
